// File: rtl/cmlk_axis_pkg.sv
// Shared definitions for the Camera Link pixel FIFO -> AXI4-Stream drain.
// Contents: default geometry/width parameters, drain FSM state enum,
// frame counter width, and a counter-width helper (minimum 1 bit).
package cmlk_axis_pkg;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_LINE_WORDS  = 1024;
    localparam int unsigned DEF_FRAME_LINES = 768;
    localparam int unsigned FRAME_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Counter width for a modulus n; a modulus of 1 still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_frame_pos.sv
// Column/line position tracker for a raster of LINE_WORDS x FRAME_LINES words.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   step      - advance one word position
//   sol, eol  - current word is first / last of its line
//   sof, eof  - current word is first / last of the frame
// Flags describe the position the next stepped word will occupy and are
// registered alongside the counters.
module axis_frame_pos
    import cmlk_axis_pkg::*;
#(
    parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
    parameter int unsigned FRAME_LINES = DEF_FRAME_LINES
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic sol,
    output logic eol,
    output logic sof,
    output logic eof
);

    localparam int unsigned COL_W  = cnt_w(LINE_WORDS);
    localparam int unsigned LINE_W = cnt_w(FRAME_LINES);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_WORDS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);

    logic [COL_W-1:0]  col_q,  col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;

    // Next position and its decoded flags.
    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        if (step) begin
            if (col_q == COL_LAST) begin
                col_d  = '0;
                line_d = (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        sol_d = (col_d == '0);
        eol_d = (col_d == COL_LAST);
        sof_d = sol_d && (line_d == '0);
        eof_d = eol_d && (line_d == LINE_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            line_q <= '0;
            sol_q  <= 1'b1;
            eol_q  <= (COL_LAST == '0);
            sof_q  <= 1'b1;
            eof_q  <= (COL_LAST == '0) && (LINE_LAST == '0);
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
            sol_q  <= sol_d;
            eol_q  <= eol_d;
            sof_q  <= sof_d;
            eof_q  <= eof_d;
        end
    end

    assign sol = sol_q;
    assign eol = eol_q;
    assign sof = sof_q;
    assign eof = eof_q;

endmodule

// File: rtl/fifo_to_axi4s.sv
// Drains a FWFT pixel FIFO into an AXI4-Stream master with video framing
// (tuser = start of frame, tlast = end of line).
// Ports:
//   clk, rst                 - read-domain clock, synchronous active-high reset
//   enable                   - run request, honoured only at frame boundaries
//   fifo_empty, fifo_dout    - FWFT status and head word
//   fifo_rd_en               - pop strobe (combinational on tready/fifo_empty)
//   m_axis_t*                - single-stage registered stream output
//   frame_done, frame_cnt    - completed-frame pulse and wrapping counter
//   busy                     - high while the drain FSM is not idle
module fifo_to_axi4s
    import cmlk_axis_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
    parameter int unsigned FRAME_LINES = DEF_FRAME_LINES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_W-1:0]      fifo_dout,
    output logic                   fifo_rd_en,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy
);

    state_e state_q, state_d;

    logic [DATA_W-1:0]      tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   tuser_q, tuser_d;
    logic                   tag_q, tag_d;        // held beat is the frame end
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   busy_q, busy_d;

    logic accept_c, pop_c;
    logic sol, eol, sof, eof;

    assign accept_c = !tvalid_q || m_axis_tready;
    assign pop_c    = (state_q == RUN) && !fifo_empty && accept_c;

    axis_frame_pos #(
        .LINE_WORDS  (LINE_WORDS),
        .FRAME_LINES (FRAME_LINES)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .step (pop_c),
        .sol  (sol),
        .eol  (eol),
        .sof  (sof),
        .eof  (eof)
    );

    // Start of frame is always also a start of line.
    assert property (@(posedge clk) disable iff (rst) sof |-> sol);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: enable is only looked at in IDLE and on the frame-end pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (pop_c && eof && !enable) state_d = DRAIN;
            DRAIN:   if (accept_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output register next values and pop strobe.
    always_comb begin
        fifo_rd_en   = pop_c;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        tag_d        = tag_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        busy_d       = (state_d != IDLE);

        if (pop_c) begin
            tdata_d  = fifo_dout;
            tvalid_d = 1'b1;
            tlast_d  = eol;
            tuser_d  = sof;
            tag_d    = eof;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
            tag_d    = 1'b0;
        end

        if (tvalid_q && m_axis_tready && tag_q) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tag_q        <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tag_q        <= tag_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fifo_to_axi4s.sv
// Directed bench for fifo_to_axi4s: a 4x2 instance for framing/flow-control
// scenarios and a 1x1 instance for the frame counter wrap.
module tb_fifo_to_axi4s;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, enable, fifo_empty, tready;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en, tvalid, tlast, tuser, frame_done, busy;
    logic [31:0] tdata;
    logic [15:0] frame_cnt;

    logic        enable1, fifo1_empty, tready1;
    logic [31:0] fifo1_dout;
    logic        fifo1_rd_en, tvalid1, tlast1, tuser1, frame_done1, busy1;
    logic [31:0] tdata1;
    logic [15:0] frame_cnt1;

    beat_t       obs[$], obs1[$], exp_q[$];
    int unsigned obs_cyc[$];
    logic [15:0] done_q[$], done1_q[$];
    logic [31:0] fq[$];
    int unsigned f1_left;
    logic [31:0] f1_data;
    bit          rec1, stall_prev, rst_prev;
    beat_t       held;
    int unsigned pass_cnt, check_cnt, cyc;

    always #5 clk = ~clk;

    fifo_to_axi4s #(.DATA_W(32), .LINE_WORDS(4), .FRAME_LINES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
    );

    fifo_to_axi4s #(.DATA_W(32), .LINE_WORDS(1), .FRAME_LINES(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable1),
        .fifo_empty(fifo1_empty), .fifo_dout(fifo1_dout), .fifo_rd_en(fifo1_rd_en),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
        .m_axis_tlast(tlast1), .m_axis_tuser(tuser1),
        .frame_done(frame_done1), .frame_cnt(frame_cnt1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_cnt = check_cnt + 1;
        assert (got === want) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    task automatic drive_fifo();
        if (fq.size() == 0) begin
            fifo_empty = 1'b1;
            fifo_dout  = '0;
        end else begin
            fifo_empty = 1'b0;
            fifo_dout  = fq[0];
        end
        fifo1_empty = (f1_left == 0);
        fifo1_dout  = f1_data;
    endtask

    function automatic void eb(input logic [31:0] d, input logic l, input logic u);
        beat_t b;
        b.d = d;
        b.l = l;
        b.u = u;
        exp_q.push_back(b);
    endfunction

    // One clock: monitor at the falling edge, apply FIFO pops after the rise.
    task automatic step();
        bit rd_s, rd1_s;
        @(negedge clk);
        rd_s  = fifo_rd_en;
        rd1_s = fifo1_rd_en;
        if (tvalid && tready) begin
            obs.push_back('{d: tdata, l: tlast, u: tuser});
            obs_cyc.push_back(cyc);
        end
        if (stall_prev && !rst_prev) begin
            chk("stall_tvalid", 32'(tvalid), 32'd1);
            chk("stall_tdata", tdata, held.d);
            chk("stall_tlast", 32'(tlast), 32'(held.l));
            chk("stall_tuser", 32'(tuser), 32'(held.u));
        end
        if (tvalid && !tready) begin
            chk("rd_en_in_stall", 32'(fifo_rd_en), 32'd0);
            held = '{d: tdata, l: tlast, u: tuser};
        end
        stall_prev = tvalid && !tready;
        rst_prev   = rst;
        if (frame_done) done_q.push_back(frame_cnt);
        if (rec1 && tvalid1 && tready1) obs1.push_back('{d: tdata1, l: tlast1, u: tuser1});
        if (rec1 && frame_done1) done1_q.push_back(frame_cnt1);
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (rd_s) void'(fq.pop_front());
        if (rd1_s) begin
            f1_data = f1_data + 32'd1;
            f1_left = f1_left - 1;
        end
        drive_fifo();
    endtask

    task automatic wait_obs(input int unsigned n, input int unsigned max, input string tag);
        for (int i = 0; i < int'(max) && obs.size() < int'(n); i++) step();
        chk(tag, 32'(obs.size() >= int'(n)), 32'd1);
    endtask

    task automatic cmp_beats(input string tag, input beat_t got[$], input beat_t want[$]);
        chk({tag, "_count"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < got.size() && i < want.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got[i].d, want[i].d);
            chk($sformatf("%s_last%0d", tag, i), 32'(got[i].l), 32'(want[i].l));
            chk($sformatf("%s_user%0d", tag, i), 32'(got[i].u), 32'(want[i].u));
        end
    endtask

    // Expected 4x2 frame for words base..base+7.
    function automatic void exp_frame(input int unsigned base);
        for (int i = 0; i < 8; i++) eb(32'(base + i), (i == 3) || (i == 7), i == 0);
    endfunction

    task automatic clear_obs();
        obs.delete();
        obs_cyc.delete();
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        pass_cnt = 0; check_cnt = 0; cyc = 0;
        rst = 1'b1; enable = 1'b0; tready = 1'b0;
        enable1 = 1'b0; tready1 = 1'b0;
        f1_left = 0; f1_data = '0; rec1 = 1'b0;
        stall_prev = 1'b0; rst_prev = 1'b1; held = '0;
        drive_fifo();

        // Reset state
        step(); step(); step();
        rst = 1'b0;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tuser", 32'(tuser), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);

        // 1: full frame at full rate
        clear_obs();
        for (int i = 0; i < 8; i++) fq.push_back(32'(i));
        drive_fifo();
        enable = 1'b1; tready = 1'b1;
        wait_obs(8, 20, "s1_timeout");
        step(); step();
        exp_frame(0);
        cmp_beats("s1", obs, exp_q);
        for (int i = 1; i < obs_cyc.size(); i++)
            chk($sformatf("s1_cycle%0d", i), obs_cyc[i] - obs_cyc[0], 32'(i));
        chk("s1_done_count", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) chk("s1_done_cnt", 32'(done_q[0]), 32'd1);
        chk("s1_busy", 32'(busy), 32'd1);

        // 2: backpressure pattern 1,0,0,1
        clear_obs();
        for (int i = 0; i < 8; i++) fq.push_back(32'(i));
        drive_fifo();
        for (int k = 0; k < 60 && obs.size() < 8; k++) begin
            tready = (k % 4 == 0) || (k % 4 == 3);
            step();
        end
        tready = 1'b1;
        step(); step();
        exp_frame(0);
        cmp_beats("s2", obs, exp_q);
        chk("s2_done_count", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) chk("s2_done_cnt", 32'(done_q[0]), 32'd2);

        // 3: FIFO runs dry after word 2
        clear_obs();
        for (int i = 0; i < 3; i++) fq.push_back(32'(i));
        drive_fifo();
        for (int i = 0; i < 8; i++) step();
        chk("s3_gap_tvalid", 32'(tvalid), 32'd0);
        chk("s3_gap_beats", 32'(obs.size()), 32'd3);
        chk("s3_gap_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) step();
        for (int i = 3; i < 8; i++) fq.push_back(32'(i));
        drive_fifo();
        wait_obs(8, 30, "s3_timeout");
        step(); step();
        exp_frame(0);
        cmp_beats("s3", obs, exp_q);
        chk("s3_frame_cnt", 32'(frame_cnt), 32'd3);

        // 4: enable dropped mid-frame, frame completes, then stop
        clear_obs();
        for (int i = 0; i < 12; i++) fq.push_back(32'(i));
        drive_fifo();
        wait_obs(6, 30, "s4_timeout");
        enable = 1'b0;
        for (int i = 0; i < 12; i++) step();
        exp_frame(0);
        cmp_beats("s4", obs, exp_q);
        chk("s4_frame_cnt", 32'(frame_cnt), 32'd4);
        chk("s4_busy", 32'(busy), 32'd0);
        chk("s4_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("s4_fifo_left", 32'(fq.size()), 32'd4);
        chk("s4_tvalid", 32'(tvalid), 32'd0);

        // 4b: one-cycle enable pulse runs a whole frame
        clear_obs();
        enable = 1'b1;
        step();
        enable = 1'b0;
        for (int i = 12; i < 16; i++) fq.push_back(32'(i));
        drive_fifo();
        wait_obs(8, 30, "s4b_timeout");
        step(); step(); step();
        exp_frame(8);
        cmp_beats("s4b", obs, exp_q);
        chk("s4b_frame_cnt", 32'(frame_cnt), 32'd5);
        chk("s4b_busy", 32'(busy), 32'd0);

        // 5: reset while word 2 is stalled
        clear_obs();
        for (int i = 0; i < 8; i++) fq.push_back(32'(i));
        drive_fifo();
        enable = 1'b1; tready = 1'b1;
        wait_obs(2, 20, "s5_timeout");
        tready = 1'b0;
        step();
        chk("s5_held_tvalid", 32'(tvalid), 32'd1);
        chk("s5_held_tdata", tdata, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_rst_tvalid", 32'(tvalid), 32'd0);
        chk("s5_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        tready = 1'b1;
        wait_obs(7, 30, "s5_timeout2");
        step(); step();
        eb(32'd0, 1'b0, 1'b1); eb(32'd1, 1'b0, 1'b0);
        eb(32'd3, 1'b0, 1'b1); eb(32'd4, 1'b0, 1'b0); eb(32'd5, 1'b0, 1'b0);
        eb(32'd6, 1'b1, 1'b0); eb(32'd7, 1'b0, 1'b0);
        cmp_beats("s5", obs, exp_q);
        chk("s5_done_count", 32'(done_q.size()), 32'd0);
        enable = 1'b0;

        // 6: 1x1 raster, frame counter wrap
        enable1 = 1'b1; tready1 = 1'b1;
        f1_left = 65535; f1_data = '0;
        drive_fifo();
        for (int i = 0; i < 70000 && frame_cnt1 !== 16'hFFFF; i++) step();
        step(); step(); step();
        chk("s6_preload", 32'(frame_cnt1), 32'hFFFF);
        chk("s6_idle_tvalid", 32'(tvalid1), 32'd0);
        rec1 = 1'b1;
        f1_left = 3; f1_data = 32'hA0;
        drive_fifo();
        for (int i = 0; i < 8; i++) step();
        exp_q.delete();
        eb(32'hA0, 1'b1, 1'b1); eb(32'hA1, 1'b1, 1'b1); eb(32'hA2, 1'b1, 1'b1);
        cmp_beats("s6", obs1, exp_q);
        chk("s6_done_count", 32'(done1_q.size()), 32'd3);
        for (int i = 0; i < done1_q.size() && i < 3; i++)
            chk($sformatf("s6_wrap%0d", i), 32'(done1_q[i]), 32'(i));
        chk("s6_busy", 32'(busy1), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
